pulse_meter: RTL and testbench
==============================

# pulse_meter

Measures the period and high width, in `clk` cycles, of an incoming pulse train, such as the divided clock produced by our programmable pulse generator.
- Reports each completed period as a registered pair with a one-cycle valid strobe.
- Flags loss of signal with a timeout.
- Sits on the return/monitor path so firmware can confirm the generated pulse matches the programmed `period`/`width` registers.

## Interface
- `CNT_W`, 32: width of counters and measurement outputs.
- `TIMEOUT`, 100_000_000: cycles since the last rising edge after which the input is declared dead. Must satisfy 2 ≤ TIMEOUT < 2^CNT_W − 1.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: measurement enable; low forces IDLE.
- `pulse_in`  in  1: measured pulse.
- `period_out`  out  CNT_W: cycles between last two rising edges.
- `width_out`  out  CNT_W: high cycles within that period.
- `meas_valid`  out  1: one-cycle strobe when `period_out`/`width_out` update.
- `no_signal`  out  1: sticky loss-of-signal flag.

## Operation
- Sampled level `s`: `pulse_in` after the input stage (see Configuration). `s_d` is `s` delayed one cycle.
  - `rise` = s & ~s_d.
  - `fall` = ~s & s_d.
- Counter `cnt` (CNT_W):
  - Loads 1 on `rise`.
  - Otherwise increments every cycle while not IDLE.
  - Held at 0 in IDLE.
  - Cannot wrap, because the timeout fires first.
- States:
  - **IDLE**
    - On `rise` with `en`=1: go to HIGH, `cnt`←1.
    - No measurement is produced from the first edge.
  - **HIGH**
    - On `fall`: `width_cap`←`cnt`, go to LOW.
  - **LOW**
    - On `rise`: `period_out`←`cnt`, `width_out`←`width_cap`, `meas_valid`←1, `no_signal`←0, `cnt`←1, go to HIGH.
- Timeout: in HIGH or LOW, if `cnt` == TIMEOUT and no `rise` this cycle:
  - go to IDLE, `no_signal`←1;
  - `period_out`/`width_out` hold their last values.
- The timeout covers both a stuck-high and a stuck-low input.
- `en` deasserted: next state IDLE, `cnt`←0. Outputs hold, `no_signal` unchanged.
- Boundaries:
  - `rise` and `fall` are mutually exclusive per cycle.
  - A 1-cycle width with a 2-cycle period measures as width 1, period 2.
  - `rise` in the same cycle `cnt` == TIMEOUT counts as a valid measurement (period = TIMEOUT), not a timeout.
- Reset values: `period_out`=0, `width_out`=0, `meas_valid`=0, `no_signal`=0, state IDLE, all internal registers 0.
- `rst_n` low mid-measurement clears everything immediately. The first rising edge after release only arms the meter.

## Timing
- Measurement convention: for a generator configured with period P and width W, the meter reports `period_out`=P, `width_out`=W.
- `meas_valid` is exactly one cycle wide. Back-to-back strobes are spaced by the measured period (≥2 cycles).
- Latency, with `pulse_in` first sampled high at clk edge N:
  - With the macro defined: `rise` is seen internally after edge N+1, and `meas_valid`/outputs are registered at edge N+2.
  - Without the macro: `rise` is seen after edge N, and outputs are registered at edge N+1.
- `period_out` and `width_out` change only on the edge that raises `meas_valid`, so both are stable whenever `meas_valid`=1.

## Configuration
- `PULSE_METER_SYNC_EN` defined:
  - `pulse_in` passes through a 2-flop synchronizer before `s`, so it may be asynchronous to `clk`.
  - Latency is as stated above.
- Not defined:
  - `s` is a single register of `pulse_in`.
  - The input must be synchronous to `clk`.
  - Measured values are identical; only latency is one cycle shorter.

## Structure
- Package `pulse_meter_pkg` holds:
  - the state enum (IDLE, HIGH, LOW);
  - the default `CNT_W` constant.
- Sub-module `sync_2ff`: two-flop level synchronizer with async active-low reset to 0. It is instantiated only under `PULSE_METER_SYNC_EN`.
- Edge detection, the FSM, the counter and the output registers live in `pulse_meter`.

## Test plan
- Generator-style train, period 10, width 3, continuous:
  - First rise produces no strobe.
  - Each later rise gives `meas_valid` pulses 10 cycles apart, with `period_out`=10 and `width_out`=3.
- Period 2, width 1: `period_out`=2, `width_out`=1, `meas_valid` every 2nd cycle.
- TIMEOUT=50, input stuck low after a valid period of 20:
  - `no_signal`=1 exactly 50 cycles after the last rise.
  - Outputs stay at 20 and the prior width.
  - Restart: no strobe on the first rise, `no_signal` clears at the next one.
- Period change from 10/3 to 16/8 mid-stream: the first strobe after the change reports 16/8, with no blended value.
- `rst_n` pulsed low mid-HIGH, then `en` dropped for 30 cycles:
  - All outputs read 0 immediately after reset.
  - Re-arming takes one rise after `en`=1; the next valid period is then reported correctly.
- With and without `PULSE_METER_SYNC_EN`: same stimulus gives identical values, with `meas_valid` delayed by exactly 1 cycle when the macro is defined.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse_meter period/width measurement block.
package pulse_meter_pkg;

  localparam int          PM_CNT_W_DEFAULT   = 32;
  localparam int unsigned PM_TIMEOUT_DEFAULT = 100_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pm_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pulse_meter.sv
// Measures period and high width of pulse_in in clk cycles, with loss-of-signal timeout.
// Define PULSE_METER_SYNC_EN to pass pulse_in through a 2-flop synchronizer (one extra cycle latency).
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int          CNT_W   = PM_CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT = PM_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] width_out,
  output logic             meas_valid,
  output logic             no_signal
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             w_s;
  logic             r_sD;
  logic             w_rise;
  logic             w_fall;
  pm_state_e        r_state;
  pm_state_e        w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_widthCap;
  logic [CNT_W-1:0] r_periodOut;
  logic [CNT_W-1:0] r_widthOut;
  logic             r_measValid;
  logic             r_noSignal;
  logic             w_atTimeout;
  logic             w_capWidth;
  logic             w_measure;
  logic             w_timeout;

`ifdef PULSE_METER_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pulse_in),
    .o_q   (w_s)
  );
`else
  logic r_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_s <= 1'b0;
    else        r_s <= pulse_in;
  end

  assign w_s = r_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sD <= 1'b0;
    else        r_sD <= w_s;
  end

  assign w_rise      = w_s & ~r_sD;
  assign w_fall      = ~w_s & r_sD;
  assign w_atTimeout = (r_cnt == TIMEOUT_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // A rise coinciding with the timeout count is a real measurement, so timeout yields to it.
  always_comb begin
    w_capWidth = 1'b0;
    w_measure  = 1'b0;
    w_timeout  = 1'b0;
    if (en) begin
      unique case (r_state)
        HIGH: begin
          if (w_atTimeout && !w_rise) w_timeout  = 1'b1;
          else if (w_fall)            w_capWidth = 1'b1;
        end
        LOW: begin
          if (w_rise)           w_measure = 1'b1;
          else if (w_atTimeout) w_timeout = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (!en) begin
      w_stateNext = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_rise) w_stateNext = HIGH;
        HIGH: begin
          if (w_timeout)       w_stateNext = IDLE;
          else if (w_capWidth) w_stateNext = LOW;
        end
        LOW: begin
          if (w_timeout)      w_stateNext = IDLE;
          else if (w_measure) w_stateNext = HIGH;
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en || w_timeout || (r_state == IDLE && !w_rise)) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= CNT_W'(1);
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_widthCap  <= '0;
      r_periodOut <= '0;
      r_widthOut  <= '0;
      r_measValid <= 1'b0;
      r_noSignal  <= 1'b0;
    end else begin
      r_measValid <= w_measure;
      if (w_capWidth) r_widthCap <= r_cnt;
      if (w_measure) begin
        r_periodOut <= r_cnt;
        r_widthOut  <= r_widthCap;
        r_noSignal  <= 1'b0;
      end else if (w_timeout) begin
        r_noSignal  <= 1'b1;
      end
    end
  end

  assign period_out = r_periodOut;
  assign width_out  = r_widthOut;
  assign meas_valid = r_measValid;
  assign no_signal  = r_noSignal;

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter: table-driven pulse trains plus timeout, period-change and reset sequences.
module tb_pulse_meter;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 50;
`ifdef PULSE_METER_SYNC_EN
  localparam int IN_LAT = 2;
`else
  localparam int IN_LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             pulse_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] width_out;
  logic             meas_valid;
  logic             no_signal;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCnt    = 0;

  typedef struct {
    int cyc;
    int per;
    int wid;
    bit ns;
  } strobe_t;

  typedef struct {
    int period;
    int width;
    int pulses;
    int expStrobes;
    int expPeriod;
    int expWidth;
  } vec_t;

  strobe_t strobes[$];
  int      riseCycles[$];
  vec_t    vecs[5];

  pulse_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pulse_in   (pulse_in),
    .period_out (period_out),
    .width_out  (width_out),
    .meas_valid (meas_valid),
    .no_signal  (no_signal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Every strobe is logged with its cycle so spacing and latency can be checked afterwards.
  always @(negedge clk) begin
    if (meas_valid)
      strobes.push_back('{cycleCnt, int'(period_out), int'(width_out), no_signal});
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int period, input int width, input int pulses);
    for (int p = 0; p < pulses; p++) begin
      for (int i = 0; i < period; i++) begin
        if (i == 0) riseCycles.push_back(cycleCnt);
        pulse_in = (i < width);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic flushIdle();
    pulse_in = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    en = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nsCycle;
    int expPer[5];
    int expWid[5];

    vecs[0] = '{10, 3, 4, 3, 10, 3};
    vecs[1] = '{ 2, 1, 5, 4,  2, 1};
    vecs[2] = '{16, 8, 3, 2, 16, 8};
    vecs[3] = '{ 7, 6, 3, 2,  7, 6};
    vecs[4] = '{ 5, 1, 3, 2,  5, 1};

    rst_n    = 1'b0;
    en       = 1'b0;
    pulse_in = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("reset period_out", period_out, 0);
    checkOutput("reset width_out", width_out, 0);
    checkOutput("reset meas_valid", meas_valid, 0);
    checkOutput("reset no_signal", no_signal, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[v]) begin
      strobes.delete();
      riseCycles.delete();
      applyStimulus(vecs[v].period, vecs[v].width, vecs[v].pulses);
      flushIdle();
      checkOutput($sformatf("v%0d strobe count", v), strobes.size(), vecs[v].expStrobes);
      for (int k = 0; k < strobes.size() && k < vecs[v].expStrobes; k++) begin
        checkOutput($sformatf("v%0d s%0d period", v, k), strobes[k].per, vecs[v].expPeriod);
        checkOutput($sformatf("v%0d s%0d width", v, k), strobes[k].wid, vecs[v].expWidth);
        if (k > 0)
          checkOutput($sformatf("v%0d s%0d spacing", v, k),
                      strobes[k].cyc - strobes[k-1].cyc, vecs[v].expPeriod);
      end
      if (strobes.size() > 0 && riseCycles.size() > 1)
        checkOutput($sformatf("v%0d latency", v), strobes[0].cyc - riseCycles[1], IN_LAT + 1);
    end

    // Period change mid-stream: the strobes must switch cleanly from 10/3 to 16/8.
    expPer = '{10, 10, 10, 16, 16};
    expWid = '{ 3,  3,  3,  8,  8};
    strobes.delete();
    applyStimulus(10, 3, 3);
    applyStimulus(16, 8, 3);
    flushIdle();
    checkOutput("change strobe count", strobes.size(), 5);
    for (int k = 0; k < strobes.size() && k < 5; k++) begin
      checkOutput($sformatf("change s%0d period", k), strobes[k].per, expPer[k]);
      checkOutput($sformatf("change s%0d width", k), strobes[k].wid, expWid[k]);
    end

    // Stuck-low input after one 20/5 period must time out exactly TIMEOUT cycles after the strobe.
    strobes.delete();
    applyStimulus(20, 5, 2);
    pulse_in = 1'b0;
    nsCycle  = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (no_signal) begin
        nsCycle = cycleCnt;
        break;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("timeout strobe count", strobes.size(), 1);
    if (strobes.size() > 0) begin
      checkOutput("timeout strobe period", strobes[0].per, 20);
      checkOutput("timeout strobe width", strobes[0].wid, 5);
      checkOutput("timeout delay", nsCycle - strobes[0].cyc, TIMEOUT);
    end
    repeat (10) begin @(posedge clk); #1; end
    checkOutput("timeout no_signal", no_signal, 1);
    checkOutput("timeout hold period", period_out, 20);
    checkOutput("timeout hold width", width_out, 5);
    checkOutput("timeout no extra strobe", strobes.size(), 1);

    strobes.delete();
    applyStimulus(10, 3, 1);
    checkOutput("restart arm no strobe", strobes.size(), 0);
    checkOutput("restart arm no_signal held", no_signal, 1);
    applyStimulus(10, 3, 2);
    flushIdle();
    checkOutput("restart strobe count", strobes.size(), 2);
    if (strobes.size() > 0) begin
      checkOutput("restart first ns", strobes[0].ns, 0);
      checkOutput("restart first period", strobes[0].per, 10);
      checkOutput("restart first width", strobes[0].wid, 3);
    end
    checkOutput("restart no_signal cleared", no_signal, 0);

    // Reset asserted while the input is high, then enable held low for 30 cycles.
    applyStimulus(10, 3, 2);
    pulse_in = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset period_out", period_out, 0);
    checkOutput("midreset width_out", width_out, 0);
    checkOutput("midreset meas_valid", meas_valid, 0);
    checkOutput("midreset no_signal", no_signal, 0);
    @(posedge clk);
    #1;
    pulse_in = 1'b0;
    en       = 1'b0;
    rst_n    = 1'b1;
    repeat (30) begin @(posedge clk); #1; end
    checkOutput("en low period_out", period_out, 0);
    en = 1'b1;
    strobes.delete();
    applyStimulus(12, 4, 1);
    checkOutput("rearm no strobe", strobes.size(), 0);
    applyStimulus(12, 4, 2);
    flushIdle();
    checkOutput("rearm strobe count", strobes.size(), 2);
    if (strobes.size() > 0) begin
      checkOutput("rearm period", strobes[0].per, 12);
      checkOutput("rearm width", strobes[0].wid, 4);
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
